// File: rtl/cisa_dispatch_queue_pkg.sv
// Shared types for the dispatch queue: instruction-type encoding, FIFO entry
// layout and FSM states.
package cisa_dispatch_queue_pkg;

    localparam int ADDR_W    = 18;
    localparam int PAYLOAD_W = 9;

    typedef enum logic [1:0] {
        INSTR_TYPE_LOOP       = 2'd0,
        INSTR_TYPE_RAM        = 2'd1,
        INSTR_TYPE_LOAD_STORE = 2'd2,
        INSTR_TYPE_ARITHMETIC = 2'd3
    } instr_type_t;

    // Payload is a union: arith uses [8:0], load/store [6:0], RAM [2:0].
    typedef struct packed {
        instr_type_t           instr_type;
        logic [3:0]            copy_count;
        logic [PAYLOAD_W-1:0]  payload;
        logic [ADDR_W-1:0]     cache_addr;
        logic [ADDR_W-1:0]     main_mem_addr;
        logic [ADDR_W-1:0]     d_cache_addr;
        logic [ADDR_W-1:0]     d_main_mem_addr;
    } dispatch_entry_t;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_HEAD_LOAD,
        ST_ISSUE
    } dispatch_state_t;

endpackage

// File: rtl/cisa_dispatch_queue_fifo.sv
// Synchronous FIFO with registered occupancy count; the head word is read
// combinationally from the storage array.
module dispatch_fifo #(
    parameter int WIDTH     = 8,
    parameter int LOG_DEPTH = 3
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 push,
    input  logic                 pop,
    input  logic [WIDTH-1:0]     wdata,
    output logic [WIDTH-1:0]     rdata,
    output logic [LOG_DEPTH:0]   count,
    output logic                 full,
    output logic                 empty
);

    localparam logic [LOG_DEPTH:0] FULL_COUNT = (LOG_DEPTH+1)'(2**LOG_DEPTH);

    logic [WIDTH-1:0]     mem [2**LOG_DEPTH];
    logic [LOG_DEPTH-1:0] wr_ptr;
    logic [LOG_DEPTH-1:0] rd_ptr;
    logic                 push_ok;
    logic                 pop_ok;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cisa_dispatch_queue.sv
// In-order dispatch queue: buffers control_unit entries and expands each into
// copy_count strided issues to the RAM, load/store or arithmetic unit.
module cisa_dispatch_queue #(
    parameter int LOG_DEPTH = 3,
    parameter int ADDR_W    = cisa_dispatch_queue_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              queue_we,
    input  logic [1:0]        queue_instr_type,
    input  logic [3:0]        queue_copy_count,
    input  logic [8:0]        queue_arith_instr,
    input  logic [2:0]        queue_ram_instr,
    input  logic [6:0]        queue_ld_st_instr,
    input  logic [ADDR_W-1:0] cache_addr,
    input  logic [ADDR_W-1:0] main_mem_addr,
    input  logic [ADDR_W-1:0] d_cache_addr,
    input  logic [ADDR_W-1:0] d_main_mem_addr,
    output logic              queue_full,
    output logic              queue_empty,
    output logic              ram_valid,
    input  logic              ram_ready,
    output logic              ld_st_valid,
    input  logic              ld_st_ready,
    output logic              arith_valid,
    input  logic              arith_ready,
    output logic [8:0]        issue_arith_instr,
    output logic [2:0]        issue_ram_instr,
    output logic [6:0]        issue_ld_st_instr,
    output logic [ADDR_W-1:0] issue_cache_addr,
    output logic [ADDR_W-1:0] issue_main_mem_addr,
    output logic              issue_last,
    output logic              dispatch_idle,
    output logic              dispatch_error
);

    import cisa_dispatch_queue_pkg::*;

    localparam int ENTRY_W = $bits(dispatch_entry_t);

    dispatch_state_t   state, state_next;
    dispatch_entry_t   push_entry, head;
    logic [ENTRY_W-1:0] fifo_rdata;
    logic [LOG_DEPTH:0] fifo_count;
    logic              fifo_full, fifo_empty;
    logic              push_ok, pop, load, fire, last, err_set, more_after_pop;

    instr_type_t       cur_type;
    logic [3:0]        cur_count, cur_idx;
    logic [8:0]        cur_payload;
    logic [ADDR_W-1:0] cur_cache, cur_main, cur_dcache, cur_dmain;
    logic              error_q;

    always_comb begin
        push_entry                 = '0;
        push_entry.instr_type      = instr_type_t'(queue_instr_type);
        push_entry.copy_count      = queue_copy_count;
        push_entry.cache_addr      = cache_addr;
        push_entry.main_mem_addr   = main_mem_addr;
        push_entry.d_cache_addr    = d_cache_addr;
        push_entry.d_main_mem_addr = d_main_mem_addr;
        case (instr_type_t'(queue_instr_type))
            INSTR_TYPE_RAM:        push_entry.payload = {6'd0, queue_ram_instr};
            INSTR_TYPE_LOAD_STORE: push_entry.payload = {2'd0, queue_ld_st_instr};
            default:               push_entry.payload = queue_arith_instr;
        endcase
    end

    dispatch_fifo #(
        .WIDTH     (ENTRY_W),
        .LOG_DEPTH (LOG_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (queue_we),
        .pop     (pop),
        .wdata   (push_entry),
        .rdata   (fifo_rdata),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign head           = dispatch_entry_t'(fifo_rdata);
    assign push_ok        = queue_we && !fifo_full;
    assign more_after_pop = (fifo_count > (LOG_DEPTH+1)'(1)) || push_ok;
    assign last           = (state == ST_ISSUE) && (cur_idx == cur_count - 4'd1);

    always_comb begin
        state_next  = state;
        pop         = 1'b0;
        load        = 1'b0;
        fire        = 1'b0;
        err_set     = queue_we && fifo_full;
        ram_valid   = 1'b0;
        ld_st_valid = 1'b0;
        arith_valid = 1'b0;
        case (state)
            // Looking at the incoming push lets HEAD_LOAD coincide with the
            // first cycle the new entry is readable from the FIFO.
            ST_EMPTY: begin
                if (!fifo_empty || push_ok) state_next = ST_HEAD_LOAD;
            end
            ST_HEAD_LOAD: begin
                if (fifo_empty) begin
                    state_next = ST_EMPTY;
                end else begin
                    load = 1'b1;
                    if (head.copy_count == 4'd0 || head.instr_type == INSTR_TYPE_LOOP) begin
                        pop = 1'b1;
                        if (head.instr_type == INSTR_TYPE_LOOP) err_set = 1'b1;
                        state_next = more_after_pop ? ST_HEAD_LOAD : ST_EMPTY;
                    end else begin
                        state_next = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                ram_valid   = (cur_type == INSTR_TYPE_RAM);
                ld_st_valid = (cur_type == INSTR_TYPE_LOAD_STORE);
                arith_valid = (cur_type == INSTR_TYPE_ARITHMETIC);
                fire = (ram_valid && ram_ready) || (ld_st_valid && ld_st_ready) ||
                       (arith_valid && arith_ready);
                if (fire && last) begin
                    pop        = 1'b1;
                    state_next = more_after_pop ? ST_HEAD_LOAD : ST_EMPTY;
                end
            end
            default: state_next = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_EMPTY;
            cur_type    <= INSTR_TYPE_LOOP;
            cur_count   <= '0;
            cur_idx     <= '0;
            cur_payload <= '0;
            cur_cache   <= '0;
            cur_main    <= '0;
            cur_dcache  <= '0;
            cur_dmain   <= '0;
            error_q     <= 1'b0;
        end else begin
            state   <= state_next;
            error_q <= error_q | err_set;
            if (load) begin
                cur_type    <= head.instr_type;
                cur_count   <= head.copy_count;
                cur_idx     <= '0;
                cur_payload <= head.payload;
                cur_cache   <= head.cache_addr;
                cur_main    <= head.main_mem_addr;
                cur_dcache  <= head.d_cache_addr;
                cur_dmain   <= head.d_main_mem_addr;
            end else if (fire) begin
                cur_idx   <= cur_idx + 4'd1;
                cur_cache <= cur_cache + cur_dcache;
                cur_main  <= cur_main + cur_dmain;
            end
        end
    end

    assign queue_full          = fifo_full;
    assign queue_empty         = fifo_empty;
    assign issue_arith_instr   = cur_payload;
    assign issue_ram_instr     = cur_payload[2:0];
    assign issue_ld_st_instr   = cur_payload[6:0];
    assign issue_cache_addr    = cur_cache;
    assign issue_main_mem_addr = cur_main;
    assign issue_last          = last;
    assign dispatch_idle       = (state == ST_EMPTY) && fifo_empty && !queue_we;
    assign dispatch_error      = error_q;

endmodule

// File: tb/tb_cisa_dispatch_queue.sv
// Directed bench for cisa_dispatch_queue with hand-computed expectations;
// inputs change and outputs are sampled 1ns after each rising edge.
module tb_cisa_dispatch_queue;

    localparam int AW = 18;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          queue_we;
    logic [1:0]    queue_instr_type;
    logic [3:0]    queue_copy_count;
    logic [8:0]    queue_arith_instr;
    logic [2:0]    queue_ram_instr;
    logic [6:0]    queue_ld_st_instr;
    logic [AW-1:0] cache_addr, main_mem_addr, d_cache_addr, d_main_mem_addr;
    logic          queue_full, queue_empty;
    logic          ram_valid, ram_ready, ld_st_valid, ld_st_ready, arith_valid, arith_ready;
    logic [8:0]    issue_arith_instr;
    logic [2:0]    issue_ram_instr;
    logic [6:0]    issue_ld_st_instr;
    logic [AW-1:0] issue_cache_addr, issue_main_mem_addr;
    logic          issue_last, dispatch_idle, dispatch_error;

    int tests_run    = 0;
    int tests_failed = 0;

    localparam logic [1:0] T_RAM = 2'd1, T_LS = 2'd2, T_AR = 2'd3;

    cisa_dispatch_queue #(.LOG_DEPTH(3), .ADDR_W(AW)) dut (
        .clk(clk), .reset_n(reset_n), .queue_we(queue_we),
        .queue_instr_type(queue_instr_type), .queue_copy_count(queue_copy_count),
        .queue_arith_instr(queue_arith_instr), .queue_ram_instr(queue_ram_instr),
        .queue_ld_st_instr(queue_ld_st_instr), .cache_addr(cache_addr),
        .main_mem_addr(main_mem_addr), .d_cache_addr(d_cache_addr),
        .d_main_mem_addr(d_main_mem_addr), .queue_full(queue_full),
        .queue_empty(queue_empty), .ram_valid(ram_valid), .ram_ready(ram_ready),
        .ld_st_valid(ld_st_valid), .ld_st_ready(ld_st_ready),
        .arith_valid(arith_valid), .arith_ready(arith_ready),
        .issue_arith_instr(issue_arith_instr), .issue_ram_instr(issue_ram_instr),
        .issue_ld_st_instr(issue_ld_st_instr), .issue_cache_addr(issue_cache_addr),
        .issue_main_mem_addr(issue_main_mem_addr), .issue_last(issue_last),
        .dispatch_idle(dispatch_idle), .dispatch_error(dispatch_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] t, input logic [3:0] cc, input logic [8:0] pl,
                        input logic [AW-1:0] ca, input logic [AW-1:0] ma,
                        input logic [AW-1:0] dc, input logic [AW-1:0] dm);
        queue_we          = 1'b1;
        queue_instr_type  = t;
        queue_copy_count  = cc;
        queue_arith_instr = pl;
        queue_ram_instr   = pl[2:0];
        queue_ld_st_instr = pl[6:0];
        cache_addr        = ca;
        main_mem_addr     = ma;
        d_cache_addr      = dc;
        d_main_mem_addr   = dm;
        tick();
        queue_we = 1'b0;
    endtask

    logic [8:0] seen [8];
    int         n_seen;

    initial begin
        reset_n = 1'b0; queue_we = 1'b0; queue_instr_type = '0; queue_copy_count = '0;
        queue_arith_instr = '0; queue_ram_instr = '0; queue_ld_st_instr = '0;
        cache_addr = '0; main_mem_addr = '0; d_cache_addr = '0; d_main_mem_addr = '0;
        ram_ready = 1'b1; ld_st_ready = 1'b1; arith_ready = 1'b1;
        #3;
        check("rst_valids", {ram_valid, ld_st_valid, arith_valid}, 0);
        check("rst_empty", queue_empty, 1);
        check("rst_full", queue_full, 0);
        check("rst_idle", dispatch_idle, 1);
        check("rst_error", dispatch_error, 0);
        check("rst_addr", issue_cache_addr, 0);
        tick();
        reset_n = 1'b1;
        tick();

        // RAM, three copies, cache stride 2, main stride 0
        push(T_RAM, 4'd3, 9'h005, 18'd0, 18'd3, 18'd2, 18'd0);
        check("t1_latency", ram_valid, 0);
        tick();
        check("t1_v0", ram_valid, 1);
        check("t1_c0", issue_cache_addr, 0);
        check("t1_m0", issue_main_mem_addr, 3);
        check("t1_l0", issue_last, 0);
        check("t1_pl", issue_ram_instr, 3'h5);
        check("t1_busy", dispatch_idle, 0);
        tick();
        check("t1_v1", ram_valid, 1);
        check("t1_c1", issue_cache_addr, 2);
        check("t1_l1", issue_last, 0);
        tick();
        check("t1_v2", ram_valid, 1);
        check("t1_c2", issue_cache_addr, 4);
        check("t1_m2", issue_main_mem_addr, 3);
        check("t1_l2", issue_last, 1);
        tick();
        check("t1_done", ram_valid, 0);
        check("t1_idle", dispatch_idle, 1);

        // ld/st stalled by ready, arith queued behind it
        ld_st_ready = 1'b0;
        push(T_LS, 4'd1, 9'h055, 18'd0, 18'd0, 18'd0, 18'd0);
        push(T_AR, 4'd1, 9'h1A5, 18'd0, 18'd0, 18'd0, 18'd0);
        for (int i = 0; i < 5; i++) begin
            check("t2_ls_hold", ld_st_valid, 1);
            check("t2_ls_pl", issue_ld_st_instr, 7'h55);
            check("t2_ar_wait", arith_valid, 0);
            tick();
        end
        ld_st_ready = 1'b1;
        tick();
        check("t2_gap", {ld_st_valid, arith_valid}, 0);
        tick();
        check("t2_ar_v", arith_valid, 1);
        check("t2_ar_pl", issue_arith_instr, 9'h1A5);
        check("t2_ar_last", issue_last, 1);
        tick();
        check("t2_ar_done", arith_valid, 0);

        // cache address wrap
        push(T_AR, 4'd2, 9'h001, 18'h3FFFF, 18'd0, 18'd1, 18'd0);
        tick();
        check("t5_c0", issue_cache_addr, 18'h3FFFF);
        tick();
        check("t5_c1", issue_cache_addr, 18'h00000);
        check("t5_last", issue_last, 1);
        tick();

        // zero-copy entry followed by arith
        push(T_RAM, 4'd0, 9'h003, 18'd0, 18'd0, 18'd0, 18'd0);
        push(T_AR, 4'd1, 9'h0F0, 18'd0, 18'd0, 18'd0, 18'd0);
        check("t4_skip", {ram_valid, ld_st_valid, arith_valid}, 0);
        tick();
        check("t4_ar_v", arith_valid, 1);
        check("t4_ram_v", ram_valid, 0);
        check("t4_ar_pl", issue_arith_instr, 9'h0F0);
        tick();
        check("t4_empty", queue_empty, 1);
        check("t4_err", dispatch_error, 0);

        // fill the queue with all units stalled
        ram_ready = 1'b0; ld_st_ready = 1'b0; arith_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            push(T_AR, 4'd1, 9'(i + 1), 18'd0, 18'd0, 18'd0, 18'd0);
        end
        check("t3_full", queue_full, 1);
        check("t3_noerr", dispatch_error, 0);
        push(T_AR, 4'd1, 9'h1FF, 18'd0, 18'd0, 18'd0, 18'd0);
        check("t3_err", dispatch_error, 1);
        check("t3_full2", queue_full, 1);
        arith_ready = 1'b1;
        n_seen = 0;
        for (int c = 0; c < 40 && n_seen < 8; c++) begin
            if (arith_valid) begin
                seen[n_seen] = issue_arith_instr;
                n_seen++;
            end
            tick();
        end
        check("t3_drained", n_seen, 8);
        for (int i = 0; i < 8; i++) begin
            check("t3_order", (i < n_seen) ? seen[i] : 9'h000, i + 1);
        end
        tick();
        check("t3_idle", dispatch_idle, 1);
        check("t3_sticky", dispatch_error, 1);

        // reset in the middle of a four-copy entry
        ram_ready = 1'b1;
        push(T_RAM, 4'd4, 9'h002, 18'h10, 18'd0, 18'd1, 18'd0);
        tick();
        tick();
        check("t6_copy2", issue_cache_addr, 18'h11);
        check("t6_v", ram_valid, 1);
        #2 reset_n = 1'b0;
        #1;
        check("t6_rst_v", {ram_valid, ld_st_valid, arith_valid}, 0);
        check("t6_rst_empty", queue_empty, 1);
        check("t6_rst_err", dispatch_error, 0);
        check("t6_rst_addr", issue_cache_addr, 0);
        #2 reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t6_quiet", {ram_valid, ld_st_valid, arith_valid}, 0);
        end
        check("t6_idle", dispatch_idle, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
